// File: rtl/alu_gen2_pkg.sv
// alu_gen2_pkg: opcode and FSM state types shared by the alu_gen2 design files.
package alu_pkg;
    typedef enum logic [2:0] {NOP = 3'd0, ADD, AND, XOR, MUL, SUB, NOT, INC} opcode_t;
    typedef enum logic [1:0] {IDLE, EXEC, MULT, RESP} state_t;
endpackage

// File: rtl/alu_gen2_if.sv
// alu_gen2_if: request/response handshake bundle between a requester and alu_gen2.
interface alu_gen2_if #(parameter int WIDTH = 8);
    import alu_pkg::*;
    logic               start;
    logic               ready;
    logic               done;
    logic               ack;
    logic               err;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    opcode_t            opcode;
    logic [2*WIDTH-1:0] result;
    modport master (output start, A, B, opcode, ack, input ready, done, result, err);
    modport slave  (input start, A, B, opcode, ack, output ready, done, result, err);
endinterface

// File: rtl/alu_gen2_mul.sv
// alu_gen2_mul: shift-add multiplier, one partial product per cycle for WIDTH cycles.
module alu_gen2_mul #(parameter int WIDTH = 8) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [5:0]         cnt;
    // product is the accumulator after the current step, so the final step's value is visible with done
    assign done    = busy && cnt == 6'd1;
    assign product = acc + (mplier[0] ? mcand : '0);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= 6'(WIDTH);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 6'd1;
            busy   <= cnt != 6'd1;
        end
    end
endmodule

// File: rtl/alu_gen2.sv
// alu_gen2: handshaked multi-op ALU with a 4-state FSM.
// Build option: define ALU_GEN2_MUL_EN to include the shift-add multiplier; otherwise MUL answers err=1.
module alu_gen2
    import alu_pkg::*;
#(parameter int WIDTH = 8) (
    input logic       clk,
    input logic       reset,
    alu_gen2_if.slave bus
);
    state_t             state, state_nx;
    opcode_t            op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] a_z, b_z, exec_res, result_q, mul_product;
    logic               err_q, exec_err, accept, is_mul, mul_busy, mul_done;
    assign accept     = bus.start && bus.ready;
    assign a_z        = {{WIDTH{1'b0}}, a_q};
    assign b_z        = {{WIDTH{1'b0}}, b_q};
    assign bus.ready  = state == IDLE;
    assign bus.done   = state == RESP;
    assign bus.result = result_q;
    assign bus.err    = err_q;
`ifdef ALU_GEN2_MUL_EN
    assign is_mul   = bus.opcode == MUL;
    assign exec_err = 1'b0;
    alu_gen2_mul #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .reset(reset), .start(accept && is_mul), .a(bus.A), .b(bus.B),
        .busy(mul_busy), .done(mul_done), .product(mul_product)
    );
`else
    assign is_mul      = 1'b0;
    assign exec_err    = op_q == MUL;
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif
    always_comb begin
        exec_res = '0;
        case (op_q)
            ADD:     exec_res = a_z + b_z;
            AND:     exec_res = a_z & b_z;
            XOR:     exec_res = a_z ^ b_z;
            SUB:     exec_res = a_z - b_z;
            NOT:     exec_res = {{WIDTH{1'b0}}, ~a_q};
            INC:     exec_res = a_z + b_z + (2*WIDTH)'(1);
            default: exec_res = '0;
        endcase
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? (is_mul ? MULT : EXEC) : IDLE;
            EXEC:    state_nx = RESP;
            MULT:    state_nx = (mul_busy && !mul_done) ? MULT : RESP;
            RESP:    state_nx = bus.ack ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= NOP;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= bus.opcode;
            end
            if (state == EXEC) begin
                result_q <= exec_res;
                err_q    <= exec_err;
            end
            if (state == MULT && mul_done) begin
                result_q <= mul_product;
                err_q    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_gen2.sv
// tb_alu_gen2: directed and random scoreboard bench for alu_gen2 at WIDTH=8.
module tb_alu_gen2;
    import alu_pkg::*;
    localparam int W = 8;
`ifdef ALU_GEN2_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif
    typedef struct {
        logic [2*W-1:0] res;
        logic           err;
        int             lat;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];
    alu_gen2_if #(.WIDTH(W)) bus();
    alu_gen2 #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Latency counts rising edges from the acceptance edge (inclusive) until done is seen.
    function automatic exp_t model(input opcode_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ai;
        int bi;
        ai = int'(a);
        bi = int'(b);
        e.err = 1'b0;
        e.lat = 2;
        e.res = '0;
        case (op)
            ADD: e.res = 16'(ai + bi);
            AND: e.res = {8'h00, a & b};
            XOR: e.res = {8'h00, a ^ b};
            SUB: e.res = 16'(ai - bi);
            NOT: e.res = {8'h00, ~a};
            INC: e.res = 16'(ai + bi + 1);
            MUL: begin
                if (MUL_ON) begin
                    e.res = 16'(ai * bi);
                    e.lat = W + 1;
                end else e.err = 1'b1;
            end
            default: e.res = '0;
        endcase
        return e;
    endfunction
    task automatic issue(input opcode_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int n;
        n = 0;
        while (!bus.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_start", bus.ready, 1);
        bus.start  = 1'b1;
        bus.A      = a;
        bus.B      = b;
        bus.opcode = op;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        bus.start  = 1'b0;
        bus.A      = W'($urandom);
        bus.B      = W'($urandom);
        bus.opcode = opcode_t'($urandom_range(0, 7));
        n = 1;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.done, 1);
        e = sb.pop_front();
        check("latency", n, e.lat);
        check("result", bus.result, e.res);
        check("err", bus.err, e.err);
    endtask
    task automatic finish_resp();
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        check("ready_after_ack", bus.ready, 1);
        check("done_after_ack", bus.done, 0);
    endtask
    initial begin
        logic [2*W-1:0] held;
        logic           saw_done;
        bus.start  = 1'b0;
        bus.ack    = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus.opcode = NOP;
        repeat (2) @(negedge clk);
        check("reset_ready", bus.ready, 1);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        check("reset_err", bus.err, 0);
        reset = 1'b0;
        issue(ADD, 8'd255, 8'd1);
        finish_resp();
        issue(SUB, 8'd3, 8'd5);
        finish_resp();
        issue(MUL, 8'd255, 8'd255);
        finish_resp();
        issue(NOT, 8'h0F, 8'h00);
        finish_resp();
        issue(INC, 8'd255, 8'd255);
        finish_resp();
        issue(NOP, 8'd77, 8'd12);
        finish_resp();
        issue(XOR, 8'hA5, 8'h3C);
        held = bus.result;
        check("hold_initial", held, 16'h0099);
        for (int i = 0; i < 10; i++) begin
            bus.start = ~bus.start;
            bus.A     = ~bus.A;
            @(negedge clk);
            check("hold_done", bus.done, 1);
            check("hold_result", bus.result, held);
            check("hold_ready", bus.ready, 0);
        end
        bus.start = 1'b0;
        finish_resp();
        @(negedge clk);
        check("no_queued_start", bus.done, 0);
        bus.start  = 1'b1;
        bus.A      = 8'd200;
        bus.B      = 8'd100;
        bus.opcode = MUL;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_ready", bus.ready, 1);
        check("abort_done", bus.done, 0);
        check("abort_result", bus.result, 0);
        check("abort_err", bus.err, 0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            saw_done = saw_done | bus.done;
        end
        check("abort_no_response", saw_done, 0);
        for (int i = 0; i < 200; i++) begin
            issue(opcode_t'($urandom_range(0, 7)), W'($urandom), W'($urandom));
            finish_resp();
        end
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/alu_gen2.md
ALU_GEN2 -- requirements
Module: alu_gen2

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request valid; accepted when start && ready at a rising edge.
REQ-005 A  input  WIDTH  operand A, unsigned; sampled only at acceptance.
REQ-006 B  input  WIDTH  operand B, unsigned; sampled only at acceptance.
REQ-007 opcode  input  3  opcode_t; sampled only at acceptance.
REQ-008 ready  output  1  high only when the block can accept a request.
REQ-009 done  output  1  response valid; held high until acknowledged.
REQ-010 ack  input  1  response consumed when done && ack at a rising edge.
REQ-011 result  output  2*WIDTH  response data; stable while done is high.
REQ-012 err  output  1  response qualifier; meaningful only while done is high.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, MULT, RESP; ready = (state == IDLE), done = (state == RESP).
REQ-014 IDLE: on acceptance, latch A, B, opcode; go to MULT if opcode == MUL (and mul enabled), else EXEC.
REQ-015 EXEC: compute in one cycle, register result/err, go to RESP; done rises exactly 2 cycles after the acceptance edge.
REQ-016 MULT: shift-add, one partial product per cycle, exactly WIDTH cycles, then RESP; done rises WIDTH+1 cycles after the acceptance edge.
REQ-017 RESP: hold result/err; on ack go to IDLE; ack outside RESP ignored; start outside IDLE ignored, not queued.
REQ-018 Ops: NOP -> 0; ADD -> A+B (carry kept, zero-extended); AND -> A&B; XOR -> A^B; MUL -> full 2*WIDTH product; SUB -> A-B sign-extended to 2*WIDTH; NOT -> ~A zero-extended; INC -> A+B+1 (carry kept, zero-extended).
REQ-019 err SHALL be 0 for every opcode when mul is enabled.
REQ-020 Changing A, B, opcode after acceptance SHALL NOT affect the pending response.
REQ-021 Boundary: A=B=all-ones MUL SHALL give (2^WIDTH-1)^2 with no truncation; SUB with B>A SHALL give negative two's-complement value.

Reset
REQ-022 reset high SHALL asynchronously force state IDLE, ready=1, done=0, result=0, err=0, internal operand/accumulator registers 0.
REQ-023 reset asserted mid-EXEC, mid-MULT or in RESP SHALL abort the operation; no response is delivered for it.
REQ-024 first acceptance possible at first rising edge after reset deasserts.

Configuration
REQ-025 Macro ALU_GEN2_MUL_EN: defined -> MULT state and shift-add datapath present, MUL behaves per REQ-016/018.
REQ-026 ALU_GEN2_MUL_EN undefined -> no multiplier logic; MUL routed through EXEC, result=0, err=1, done 2 cycles after acceptance.

Structure
REQ-027 opcode_t (3-bit enum: NOP=0, ADD=1, AND=2, XOR=3, MUL=4, SUB=5, NOT=6, INC=7) and FSM state enum SHALL live in shared package alu_pkg.
REQ-028 Shift-add multiplier SHALL be sub-module alu_gen2_mul (start/busy/done, WIDTH parameter), instantiated only under ALU_GEN2_MUL_EN.

Verification (WIDTH=8)
REQ-029 Reset mid-MULT (A=200,B=100, reset at cycle 4) -> ready=1, done=0, result=0 immediately; no response after release.
REQ-030 ADD A=255,B=1 -> result=256, err=0, done 2 cycles after acceptance; SUB A=3,B=5 -> result=16'hFFFE.
REQ-031 MUL A=255,B=255 (macro defined) -> result=65025, done 9 cycles after acceptance; undefined -> result=0, err=1, done 2 cycles after acceptance.
REQ-032 Hold ack=0 for 10 cycles in RESP with start pulsed and A toggled -> done, result stable, ready=0, no new acceptance.
REQ-033 200 random back-to-back requests with ack on done, A/B randomised after acceptance -> every result matches REQ-018 model, 0 mismatches.
